// File: rtl/mac_array_dual.sv
// mac_array_dual: row x col MAC array with run-time weight-stationary / output-stationary dataflow,
// busy tracking, idle-only mode switching and sticky command-error reporting.
module mac_array_dual #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int row     = 8,
    parameter int col     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [1:0]             inst_w,
    input  logic [row*bw-1:0]      in_w,
    input  logic [psum_bw*col-1:0] in_n,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid,
    output logic                   busy,
    output logic                   err
);
    localparam int depth = row + col - 1;
    localparam int cw    = $clog2(row + col + 1);

    logic                   mode_q;
    logic [2:0]             skew [depth];
    logic                   drain_q;
    logic [cw-1:0]          cnt;
    logic [psum_bw*col-1:0] os_out;
    logic [psum_bw*col-1:0] bottom;
    logic [col-1:0]         valid_nx;
    logic                   drop;
    logic                   os_drain;
    logic                   mode_sw;
    logic [bw-1:0]          act    [row][col];
    logic [bw-1:0]          wgt    [row][col];
    logic                   lr     [row][col];
    logic [psum_bw-1:0]     acc    [row][col];
    logic [bw-1:0]          west   [row][col];
    logic [bw-1:0]          wgt_nx [row][col];
    logic                   lr_nx  [row][col];
    logic [psum_bw-1:0]     acc_nx [row][col];

    assign drop     = mode_q && inst_w == 2'b01 && busy;
    assign os_drain = mode_q && inst_w == 2'b01 && !busy;
    assign mode_sw  = !busy && inst_w == 2'b00 && mode != mode_q;
    assign busy     = |cnt;
    assign out_s    = mode_q ? os_out : bottom;

    for (genvar r = 0; r < row; r++) begin : g_row
        for (genvar c = 0; c < col; c++) begin : g_pe
            logic [2:0]                s;
            logic [bw-1:0]             nw;
            logic [psum_bw-1:0]        np;
            logic [psum_bw-1:0]        up;
            logic signed [bw:0]        asel;
            logic signed [bw-1:0]      wsel;
            logic signed [psum_bw-1:0] prod;
            assign s = skew[r+c];
            if (c == 0) begin : g_w0
                assign west[r][c] = in_w[r*bw +: bw];
            end else begin : g_wn
                assign west[r][c] = act[r][c-1];
            end
            if (r == 0) begin : g_n0
                assign nw = in_n[c*psum_bw +: bw];
                assign np = in_n[c*psum_bw +: psum_bw];
                assign up = '0;
            end else begin : g_nn
                assign nw = wgt[r-1][c];
                assign np = acc[r-1][c];
                assign up = acc[r-1][c];
            end
            assign asel = {1'b0, west[r][c]};
            assign wsel = s[2] ? nw : wgt[r][c];
            assign prod = psum_bw'(asel) * psum_bw'(wsel);
            // s = {mode, execute, ws_load}; a drain overrides everything because nothing is in flight
            assign acc_nx[r][c] = drain_q ? up : s[1] ? (s[2] ? acc[r][c] : np) + prod : acc[r][c];
            assign wgt_nx[r][c] = (s[0] && lr[r][c]) ? west[r][c] : (s[1] && s[2]) ? nw : wgt[r][c];
            assign lr_nx[r][c]  = lr[r][c] && !s[0];
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_col
        assign bottom[c*psum_bw +: psum_bw] = acc[row-1][c];
        assign valid_nx[c] = drain_q || (skew[row-1+c][1] && !skew[row-1+c][2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= 1'b0;
            skew    <= '{default: '0};
            drain_q <= 1'b0;
            cnt     <= '0;
            err     <= 1'b0;
            valid   <= '0;
        end else begin
            if (!busy && inst_w == 2'b00) mode_q <= mode;
            skew[0] <= {mode_q, inst_w[1], inst_w == 2'b01 && !mode_q};
            for (int i = 1; i < depth; i++) skew[i] <= skew[i-1];
            drain_q <= os_drain;
            // a drain completes in one cycle, so it never arms the busy counter
            cnt     <= (|inst_w && !(mode_q && inst_w == 2'b01)) ? cw'(row + col) : busy ? cnt - cw'(1) : cnt;
            err     <= err || inst_w == 2'b11 || drop;
            valid   <= valid_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || mode_sw) begin
            act    <= '{default: '0};
            wgt    <= '{default: '0};
            lr     <= '{default: 1'b1};
            acc    <= '{default: '0};
            os_out <= '0;
        end else begin
            act <= west;
            wgt <= wgt_nx;
            lr  <= lr_nx;
            acc <= acc_nx;
            if (drain_q) os_out <= bottom;
        end
    end
endmodule
